// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with TX/RX FIFOs, shared 16x oversampling
// tick, optional parity, one or two TX stop bits and internal loopback.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   baud_div                     tick period = baud_div+1 clk; bit = 16 ticks
//   parity_en/parity_odd/two_stop frame format, latched at each frame start
//   loopback                     internal TX feeds RX; tx pin held 1
//   rx / tx                      serial input (async) / serial output
//   tx_data/tx_valid/tx_ready    TX FIFO write handshake
//   rx_data/rx_valid/rx_ready    RX FIFO read handshake (head shown combinationally)
//   rx_frame_err/rx_parity_err   per-word error flags, aligned with rx_data
//   rx_overrun/clr_overrun       sticky RX FIFO overflow flag and its clear
//   tx_level/rx_level            FIFO occupancy
//   tx_busy                      TX frame in progress

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             push_ok, pop_ok;

  // Full/empty come from the pre-cycle level, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module uart_transceiver #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic                          loopback,
  input  logic                          rx,
  output logic                          tx,
  input  logic [DATA_SIZE-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_SIZE-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          tx_busy
);
  localparam int RW = DATA_SIZE + 2;

  // ---------------- tick generator ----------------
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;

  assign tick = (div_cnt == baud_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- TX path ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;

  tx_state_t            tx_state;
  logic [3:0]           tx_tcnt, tx_bcnt;
  logic [DATA_SIZE-1:0] tx_sr, tx_head;
  logic                 tx_par_en, tx_par_bit, tx_two, tx_line;
  logic                 tx_pop, tx_empty, tx_full;

  assign tx_ready = !tx_full;
  assign tx_pop   = (tx_state == TX_IDLE) && tick && !tx_empty;
  assign tx       = loopback ? 1'b1 : tx_line;

  uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .level   (tx_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      tx_tcnt    <= '0;
      tx_bcnt    <= '0;
      tx_sr      <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_two     <= 1'b0;
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_pop) begin
        tx_sr      <= tx_head;
        tx_par_en  <= parity_en;
        tx_par_bit <= ^tx_head ^ parity_odd;
        tx_two     <= two_stop;
        tx_line    <= 1'b0;
        tx_tcnt    <= '0;
        tx_busy    <= 1'b1;
        tx_state   <= TX_START;
      end
    end else if (tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_line  <= tx_sr[0];
            tx_bcnt  <= '0;
          end
          TX_DATA: begin
            if (tx_bcnt == 4'(DATA_SIZE-1)) begin
              tx_state <= tx_par_en ? TX_PARITY : TX_STOP1;
              tx_line  <= tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_bcnt <= tx_bcnt + 4'd1;
              tx_sr   <= tx_sr >> 1;
              tx_line <= tx_sr[1];
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP1;
            tx_line  <= 1'b1;
          end
          TX_STOP1: begin
            if (tx_two) begin
              tx_state <= TX_STOP2;
            end else begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end
          end
          default: begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- RX path ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t            rx_state;
  logic [1:0]           rx_sync;
  logic                 rx_in, rx_bit;
  logic [3:0]           rx_tcnt, rx_bcnt;
  logic [DATA_SIZE-1:0] rx_sr;
  logic                 rx_par_en, rx_par_odd, rx_perr;
  logic                 rx_push, rx_pop, rx_empty, rx_full;
  logic [RW-1:0]        rx_word, rx_head;

  assign rx_in  = loopback ? tx_line : rx;
  assign rx_bit = rx_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rx_in};
  end

  // The word is pushed on the same edge the stop bit is sampled.
  assign rx_push = (rx_state == RX_STOP) && tick && (rx_tcnt == 4'd15);
  assign rx_word = {~rx_bit, rx_perr, rx_sr};
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign {rx_frame_err, rx_parity_err, rx_data} = rx_valid ? rx_head : '0;

  uart_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .wr_data (rx_word),
    .pop     (rx_pop),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_full),
    .level   (rx_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 rx_overrun <= 1'b0;
    else if (rx_push && rx_full)  rx_overrun <= 1'b1;
    else if (clr_overrun)         rx_overrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= RX_IDLE;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_sr      <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_perr    <= 1'b0;
    end else if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_bit) begin
            rx_state   <= RX_START;
            rx_tcnt    <= '0;
            rx_par_en  <= parity_en;
            rx_par_odd <= parity_odd;
            rx_perr    <= 1'b0;
          end
        end
        RX_START: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            // Line back high at mid-start: a glitch, not a frame.
            rx_state <= rx_bit ? RX_IDLE : RX_DATA;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
          end
        end
        RX_DATA: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_sr <= {rx_bit, rx_sr[DATA_SIZE-1:1]};
            if (rx_bcnt == 4'(DATA_SIZE-1)) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
            else                            rx_bcnt  <= rx_bcnt + 4'd1;
          end
        end
        RX_PARITY: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_perr  <= rx_bit ^ (^rx_sr) ^ rx_par_odd;
            rx_state <= RX_STOP;
          end
        end
        default: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= RX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameter DATA_SIZE, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16: entries per FIFO, a power of two, legal range 2..64.
REQ-003 Parameter DIV_WIDTH, default 16: width of baud_div.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports: clk in 1, system clock; reset_n in 1, asynchronous reset, active low.
REQ-005 baud_div in DIV_WIDTH: sample-tick period, equal to baud_div+1 clk cycles.
REQ-006 parity_en in 1: enables the parity bit; parity_odd in 1: 1 selects odd parity, 0 selects even; two_stop in 1: 1 selects two stop bits.
REQ-007 loopback in 1: routes internal TX to the RX input; while loopback=1, tx is held 1.
REQ-008 rx in 1: serial input, asynchronous to clk; tx out 1: serial output.
REQ-009 tx_data in DATA_SIZE, tx_valid in 1, tx_ready out 1: TX write handshake.
REQ-010 rx_data out DATA_SIZE, rx_valid out 1, rx_ready in 1: RX read handshake.
REQ-011 rx_frame_err out 1 and rx_parity_err out 1: per-word error flags, aligned with rx_data.
REQ-012 rx_overrun out 1: sticky overrun flag; clr_overrun in 1: clears rx_overrun.
REQ-013 tx_level out and rx_level out, each $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy; tx_busy out 1: TX frame in progress.

Function
REQ-014 Tick generator: one counter that asserts tick for one clk cycle when the count equals baud_div, then reloads to 0.
REQ-015 The bit period SHALL be 16 ticks.
REQ-016 TX FIFO: tx_ready = !tx_full; a write occurs when tx_valid&tx_ready; tx_ready is determined by pre-cycle occupancy, so a write while full is blocked even if a pop occurs in the same cycle.
REQ-017 The TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; each state lasts 16 ticks per bit.
REQ-018 IDLE->START on the first tick with TX FIFO non-empty; the pop and latch of the word and of parity_en/parity_odd/two_stop occur at that point.
REQ-019 Config changes SHALL take effect only at frame boundaries.
REQ-020 TX bit sequence: start=0, data LSB first, then parity (if enabled), then stop=1 (STOP2 only if two_stop).
REQ-021 Parity: even gives XOR(data)=parity; odd gives the inverse.
REQ-022 tx_busy=1 in every TX state except IDLE.
REQ-023 RX input: a 2-flop synchroniser on rx (or on internal TX when loopback=1).
REQ-024 The RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE->START when the synchronised line is 0 on a tick.
REQ-026 START: after 8 ticks, re-sample; if 1, treat it as a glitch and return to IDLE with nothing written.
REQ-027 DATA, PARITY, STOP: sample every 16 ticks (mid-bit).
REQ-028 The RX FSM checks exactly one stop bit regardless of two_stop.
REQ-029 A STOP sample of 0 sets the frame_err bit; a parity mismatch sets the parity_err bit.
REQ-030 The RX FSM returns to IDLE immediately after the STOP sample.
REQ-031 RX FIFO word = {frame_err, parity_err, data}, written at the STOP sample.
REQ-032 If the RX FIFO is full (pre-cycle occupancy), the word is discarded and rx_overrun is set, even if a pop occurs in the same cycle.
REQ-033 rx_valid = !rx_empty; the head word is presented combinationally; a pop occurs when rx_valid&rx_ready.
REQ-034 rx_overrun clears on clr_overrun; a set and a clear in the same cycle leaves it set.
REQ-035 Levels update in the cycle after a push or pop; a simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
REQ-036 Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Reset
REQ-037 While reset_n=0, all FSMs go to IDLE, pointers, levels and counters to 0, and flags to 0.
REQ-038 Reset output values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, tx_busy=0.
REQ-039 Reset asserted mid-frame aborts the frame, flushes both FIFOs, and drives tx=1 asynchronously.
REQ-040 After reset_n deasserts, the block operates from the first clk edge.

Verification
REQ-041 baud_div=1, 8N1, write 0xA5 -> tx low 32 clk, then bits 1,0,1,0,0,1,0,1 at 32 clk each, then high; tx_busy for 320 clk.
REQ-042 loopback=1, parity_en=1, parity_odd=1, write 0x3C,0x81 -> rx_data 0x3C then 0x81, all error flags 0, tx pin held 1.
REQ-043 FIFO_DEPTH=4, 5 frames received, no reads -> rx_level=4, rx_overrun=1, reads return the first 4 bytes; clr_overrun -> 0.
REQ-044 rx driven with stop bit 0 on byte 0x55 -> word 0x55 with rx_frame_err=1; even-parity frame with a flipped parity bit -> rx_parity_err=1.
REQ-045 rx low pulse of 4 ticks -> no word, RX FSM back to IDLE.
REQ-046 reset_n pulsed mid-TX data bit -> tx=1 immediately, tx_level=0; a new write then sends a clean frame.
